// File: rtl/alu_writeback_stage.sv
// ALU result commit stage: CPSR flag commit plus a 2-entry register-file write-back FIFO.
// Optional FP sticky flag accumulator enabled by defining ALU_WB_STICKY_FP_EN.
module alu_writeback_stage #(
   parameter int WIDTH = 16,
   parameter int RD_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [6:0]       in_flags,
   input  logic [RD_W-1:0]  in_rd,
   input  logic             in_write_rd,
   input  logic             in_set_flags,
   input  logic             in_fp,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [RD_W-1:0]  wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic [6:0]       cpsr,
`ifdef ALU_WB_STICKY_FP_EN
   output logic [2:0]       fp_sticky,
   input  logic             sticky_clr,
`endif
   output logic [15:0]      retire_cnt
);

   logic [1:0]       count;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [RD_W-1:0]  rd_mem   [2];
   logic [WIDTH-1:0] data_mem [2];
   logic             accept;
   logic             push;
   logic             pop;

   // Ready depends only on the registered occupancy, never on wb_ready,
   // so a full FIFO refuses flags-only work too and CPSR stays in order.
   assign in_ready = (count < 2'd2);
   assign accept   = in_valid && in_ready;
   assign push     = accept && in_write_rd;
   assign wb_valid = (count != 2'd0);
   assign pop      = wb_valid && wb_ready;
   assign wb_rd    = rd_mem[rd_ptr];
   assign wb_data  = data_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         cpsr       <= 7'b0;
         retire_cnt <= 16'd0;
         for (int i = 0; i < 2; i++) begin
            rd_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            rd_mem[wr_ptr]   <= in_rd;
            data_mem[wr_ptr] <= in_result;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr     <= ~rd_ptr;
            retire_cnt <= retire_cnt + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         // FP-only status bits are forced clear for integer operations.
         if (accept && in_set_flags)
            cpsr <= {(in_fp ? in_flags[6:4] : 3'b000), in_flags[3:0]};
      end
   end

`ifdef ALU_WB_STICKY_FP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fp_sticky <= 3'b000;
      end else if (accept && in_fp) begin
         fp_sticky <= (sticky_clr ? 3'b000 : fp_sticky) | in_flags[6:4];
      end else if (sticky_clr) begin
         fp_sticky <= 3'b000;
      end
   end
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: queue-based reference model plus a decoupled write-back monitor.
module tb_alu_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [6:0]  in_flags;
   logic [3:0]  in_rd;
   logic        in_write_rd;
   logic        in_set_flags;
   logic        in_fp;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic [6:0]  cpsr;
   logic [15:0] retire_cnt;
`ifdef ALU_WB_STICKY_FP_EN
   logic [2:0]  fp_sticky;
   logic        sticky_clr;
   logic [2:0]  mdl_sticky;
`endif

   int          checks = 0;
   int          failures = 0;
   logic        chk_en = 1'b0;
   logic [19:0] exp_q [$];
   int          mdl_cnt = 0;
   logic [6:0]  mdl_cpsr = 7'b0;
   logic [15:0] mdl_ret = 16'd0;
   int          n_push = 0;
   int          n_pop = 0;

   alu_writeback_stage #(.WIDTH(16), .RD_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_flags     (in_flags),
      .in_rd        (in_rd),
      .in_write_rd  (in_write_rd),
      .in_set_flags (in_set_flags),
      .in_fp        (in_fp),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .cpsr         (cpsr),
`ifdef ALU_WB_STICKY_FP_EN
      .fp_sticky    (fp_sticky),
      .sticky_clr   (sticky_clr),
`endif
      .retire_cnt   (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy, CPSR and retire count evolve per the handshake rules.
   always @(negedge clk) begin
      logic acc;
      logic pp;
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(mdl_cnt < 2));
         chk("wb_valid", 32'(wb_valid), 32'(mdl_cnt != 0));
         chk("cpsr", 32'(cpsr), 32'(mdl_cpsr));
         chk("retire_cnt", 32'(retire_cnt), 32'(mdl_ret));
`ifdef ALU_WB_STICKY_FP_EN
         chk("fp_sticky", 32'(fp_sticky), 32'(mdl_sticky));
`endif
      end
      if (rst) begin
         mdl_cnt  = 0;
         mdl_cpsr = 7'b0;
         mdl_ret  = 16'd0;
         exp_q.delete();
`ifdef ALU_WB_STICKY_FP_EN
         mdl_sticky = 3'b000;
`endif
      end else begin
         acc = in_valid && (mdl_cnt < 2);
         pp  = (mdl_cnt != 0) && wb_ready;
         if (acc && in_write_rd) begin
            exp_q.push_back({in_rd, in_result});
            n_push++;
            mdl_cnt++;
         end
         if (pp) begin
            n_pop++;
            mdl_ret = mdl_ret + 16'd1;
            mdl_cnt--;
         end
         if (acc && in_set_flags)
            mdl_cpsr = in_fp ? in_flags : {3'b000, in_flags[3:0]};
`ifdef ALU_WB_STICKY_FP_EN
         if (sticky_clr) mdl_sticky = 3'b000;
         if (acc && in_fp) mdl_sticky = mdl_sticky | in_flags[6:4];
`endif
      end
   end

   // Monitor: whatever sits at the FIFO head must be the oldest outstanding write.
   always @(negedge clk) begin
      if (chk_en && !rst && wb_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_unexpected actual=rd %h data %h required=no entry at %0t", wb_rd, wb_data, $time);
         end else begin
            chk("wb_head", 32'({wb_rd, wb_data}), 32'(exp_q[0]));
            if (wb_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] res, input logic [6:0] fl, input logic [3:0] rd,
                       input logic wr, input logic sf, input logic fp);
      int n = 0;
      in_valid = 1'b1; in_result = res; in_flags = fl; in_rd = rd;
      in_write_rd = wr; in_set_flags = sf; in_fp = fp;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      chk("send_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_rd = '0;
      in_write_rd = 1'b0; in_set_flags = 1'b0; in_fp = 1'b0; wb_ready = 1'b1;
`ifdef ALU_WB_STICKY_FP_EN
      sticky_clr = 1'b0;
`endif
      @(posedge clk); #1;
      chk_en = 1'b1;
      in_valid = 1'b1; in_write_rd = 1'b1; in_set_flags = 1'b1; in_fp = 1'b1;
      in_flags = 7'h7f; in_result = 16'hbeef; in_rd = 4'h9;
      repeat (3) begin
         @(negedge clk);
         chk("rst_cpsr", 32'(cpsr), 32'd0);
         chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      for (int i = 1; i <= 4; i++)
         send(16'(i * 16'h0011), 7'h00, 4'(i), 1'b1, 1'b0, 1'b0);
      idle(3);
      @(negedge clk);
      chk("b2b_retire", 32'(retire_cnt), 32'd4);
      @(posedge clk); #1;

      wb_ready = 1'b0;
      fork
         begin
            send(16'h0011, 7'h00, 4'h1, 1'b1, 1'b0, 1'b0);
            send(16'h0022, 7'h00, 4'h2, 1'b1, 1'b0, 1'b0);
            send(16'h0033, 7'h00, 4'h3, 1'b1, 1'b0, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_full_ready", 32'(in_ready), 32'd0);
            repeat (3) begin
               chk("bp_head_hold", 32'(wb_data), 32'h0011);
               @(negedge clk);
            end
            @(posedge clk); #1;
            wb_ready = 1'b1;
         end
      join
      idle(4);

      send(16'h0000, 7'b0000110, 4'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("cmp_cpsr", 32'(cpsr), 32'h06);
      chk("cmp_no_push", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      send(16'h1234, 7'h7f, 4'h5, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("add_keep_cpsr", 32'(cpsr), 32'h06);
      @(posedge clk); #1;
      send(16'h0000, 7'b1110001, 4'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("int_mask_cpsr", 32'(cpsr), 32'h01);
      @(posedge clk); #1;
      send(16'h0000, 7'b1110001, 4'h0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("fp_cpsr", 32'(cpsr), 32'h71);
      @(posedge clk); #1;

`ifdef ALU_WB_STICKY_FP_EN
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      send(16'h0000, 7'h10, 4'h0, 1'b0, 1'b0, 1'b1);
      send(16'h0000, 7'h40, 4'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("sticky_inf_nan", 32'(fp_sticky), 32'b101);
      @(posedge clk); #1;
      sticky_clr = 1'b1;
      send(16'h0000, 7'h20, 4'h0, 1'b0, 1'b0, 1'b1);
      sticky_clr = 1'b0;
      @(negedge clk);
      chk("sticky_clr_set", 32'(fp_sticky), 32'b010);
      @(posedge clk); #1;
`endif

      repeat (400) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_result    = 16'($urandom);
         in_flags     = 7'($urandom);
         in_rd        = 4'($urandom);
         in_write_rd  = ($urandom_range(0, 3) != 0);
         in_set_flags = 1'($urandom);
         in_fp        = 1'($urandom);
         wb_ready     = 1'($urandom);
`ifdef ALU_WB_STICKY_FP_EN
         sticky_clr   = ($urandom_range(0, 7) == 0);
`endif
         @(posedge clk); #1;
      end
`ifdef ALU_WB_STICKY_FP_EN
      sticky_clr = 1'b0;
`endif
      wb_ready = 1'b1;
      idle(4);

      while (n_push < 65536) begin
         in_valid     = 1'b1;
         in_write_rd  = 1'b1;
         in_result    = 16'($urandom);
         in_rd        = 4'($urandom);
         in_flags     = 7'($urandom);
         in_set_flags = 1'($urandom);
         in_fp        = 1'($urandom);
         @(posedge clk); #1;
      end
      idle(4);
      @(negedge clk);
      chk("retire_wrap", 32'(retire_cnt), 32'd0);
      chk("all_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
